// File: rtl/rx_timing_unit_if.sv
// rx_timing_unit_if: bus lines, receive flag and timing strobes between the line interface and the USB receiver
interface rx_timing_unit_if;
    logic d_plus_raw;
    logic d_minus_raw;
    logic rcving;
    logic d_plus;
    logic d_minus;
    logic d_edge;
    logic eop;
    logic shift_enable;
    logic byte_received;

    modport master (
        output d_plus_raw, d_minus_raw, rcving,
        input  d_plus, d_minus, d_edge, eop, shift_enable, byte_received
    );

    modport slave (
        input  d_plus_raw, d_minus_raw, rcving,
        output d_plus, d_minus, d_edge, eop, shift_enable, byte_received
    );
endinterface

// File: rtl/rx_timing_unit.sv
// rx_timing_unit: synchronises D+/D-, recovers bit timing from D+ edges and flags sampled bits and whole bytes
module rx_timing_unit #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_OFFSET = 3
) (
    input logic             clk,
    input logic             n_rst,
    rx_timing_unit_if.slave bus
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] CNT_LAST   = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] CNT_SAMPLE = W'(SAMPLE_OFFSET);

    logic         dp_meta, dp_sync, dp_last;
    logic         dm_meta, dm_sync;
    logic [W-1:0] clk_cnt;
    logic [2:0]   bit_cnt;
    logic         byte_rcvd;
    logic         d_edge;
    logic         shift_en;

    // Two-flop synchronisers resetting to idle J (D+ high, D- low), plus D+ history for edge detection
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_meta <= 1'b1;
            dp_sync <= 1'b1;
            dp_last <= 1'b1;
            dm_meta <= 1'b0;
            dm_sync <= 1'b0;
        end else begin
            dp_meta <= bus.d_plus_raw;
            dp_sync <= dp_meta;
            dp_last <= dp_sync;
            dm_meta <= bus.d_minus_raw;
            dm_sync <= dm_meta;
        end
    end

    // Bit-phase counter: realigns to 1 on every D+ edge so the sample point tracks the sender's clock
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            clk_cnt <= '0;
        else
            clk_cnt <= !bus.rcving           ? '0 :
                       d_edge                ? W'(1) :
                       (clk_cnt == CNT_LAST) ? '0 :
                                               clk_cnt + 1'b1;
    end

    // Bits-in-byte counter and one-cycle byte flag raised after the eighth sample
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt   <= '0;
            byte_rcvd <= 1'b0;
        end else begin
            bit_cnt   <= !bus.rcving ? '0 : shift_en ? bit_cnt + 3'd1 : bit_cnt;
            byte_rcvd <= bus.rcving && shift_en && (bit_cnt == 3'd7);
        end
    end

    assign d_edge   = dp_sync ^ dp_last;
    assign shift_en = bus.rcving && (clk_cnt == CNT_SAMPLE);

    assign bus.d_plus        = dp_sync;
    assign bus.d_minus       = dm_sync;
    assign bus.d_edge        = d_edge;
    assign bus.eop           = !dp_sync && !dm_sync;
    assign bus.shift_enable  = shift_en;
    assign bus.byte_received = byte_rcvd;
endmodule

// File: tb/tb_rx_timing_unit.sv
// tb_rx_timing_unit: directed vectors and cycle-exact sequences for rx_timing_unit
module tb_rx_timing_unit;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Packed record: {dp_raw, dm_raw, rcving, d_plus, d_minus, d_edge, eop, shift_enable, byte_received}
    typedef struct packed {
        logic       dp;
        logic       dm;
        logic       rc;
        logic [5:0] exp;
    } vec_t;

    vec_t         tbl[18];
    logic [255:0] s_dp, s_dm, s_rc, e_se, e_br, e_eop, e_edge;
    bit           tog[256];
    logic [5:0]   rel[5];

    always #5 clk = ~clk;

    rx_timing_unit_if bus();

    rx_timing_unit dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    function automatic logic [5:0] outs6();
        return {bus.d_plus, bus.d_minus, bus.d_edge, bus.eop, bus.shift_enable, bus.byte_received};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input int idx, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d] got %b required %b", name, idx, got, want);
        end
    endtask

    task automatic idle(input int n);
        bus.d_plus_raw  = 1'b1;
        bus.d_minus_raw = 1'b0;
        bus.rcving      = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clear_seq();
        s_dp = '0; s_dm = '0; s_rc = '0;
        e_se = '0; e_br = '0; e_eop = '0; e_edge = '0;
        for (int i = 0; i < 256; i++) tog[i] = 1'b0;
    endtask

    // J/K line from a toggle list, starting at J; a toggle driven at d shows as d_edge at check d+2
    task automatic build_line(input int n);
        logic l;
        l = 1'b1;
        for (int d = 0; d < n; d++) begin
            if (tog[d]) begin
                l = ~l;
                e_edge[d + 2] = 1'b1;
            end
            s_dp[d] = l;
            s_dm[d] = ~l;
        end
    endtask

    // Drive index d=k-1 before edge k, then compare {shift_enable, byte_received, eop, d_edge} at check k
    task automatic run_seq(input string name, input int n);
        for (int k = 1; k <= n; k++) begin
            bus.d_plus_raw  = s_dp[k-1];
            bus.d_minus_raw = s_dm[k-1];
            bus.rcving      = s_rc[k-1];
            tick();
            check(name, k, {2'b00, bus.shift_enable, bus.byte_received, bus.eop, bus.d_edge},
                  {2'b00, e_se[k], e_br[k], e_eop[k], e_edge[k]});
        end
    endtask

    initial begin
        bus.d_plus_raw  = 1'b1;
        bus.d_minus_raw = 1'b0;
        bus.rcving      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", 0, outs6(), 6'b100000);
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_j", i, outs6(), 6'b100000);
        end

        tbl = '{
            9'b100_100000, 9'b100_100000, 9'b101_100000, 9'b011_100000,
            9'b011_011010, 9'b011_010000, 9'b011_010000, 9'b011_010010,
            9'b101_010000, 9'b001_101000, 9'b001_001100, 9'b001_000100,
            9'b001_000100, 9'b001_000110, 9'b000_000100, 9'b100_000100,
            9'b100_101000, 9'b100_100000
        };
        for (int i = 0; i < 18; i++) begin
            bus.d_plus_raw  = tbl[i].dp;
            bus.d_minus_raw = tbl[i].dm;
            bus.rcving      = tbl[i].rc;
            tick();
            check("vec", i, outs6(), tbl[i].exp);
        end
        idle(6);

        // Free-running sample point, then realignment after one D+ edge
        clear_seq();
        for (int d = 0; d < 28; d++) s_rc[d] = 1'b1;
        tog[4] = 1'b1;
        build_line(28);
        e_se[3] = 1'b1; e_se[9] = 1'b1; e_se[17] = 1'b1; e_se[25] = 1'b1;
        run_seq("edge_sample", 28);
        idle(6);

        // Sync byte KJKJKJKK followed back-to-back by JKJKJKJK
        clear_seq();
        for (int d = 0; d < 130; d++) s_rc[d] = 1'b1;
        for (int i = 0; i < 7; i++) tog[8*i] = 1'b1;
        for (int i = 0; i < 8; i++) tog[64 + 8*i] = 1'b1;
        build_line(130);
        for (int i = 0; i < 16; i++) e_se[5 + 8*i] = 1'b1;
        e_br[62] = 1'b1; e_br[126] = 1'b1;
        run_seq("two_bytes", 130);
        idle(6);

        // Bit edges at 7 and 9 cycle spacing
        clear_seq();
        for (int d = 0; d < 60; d++) s_rc[d] = 1'b1;
        tog[0] = 1'b1; tog[7] = 1'b1; tog[16] = 1'b1; tog[23] = 1'b1;
        tog[32] = 1'b1; tog[39] = 1'b1; tog[48] = 1'b1;
        build_line(60);
        e_se[5] = 1'b1; e_se[12] = 1'b1; e_se[21] = 1'b1; e_se[28] = 1'b1;
        e_se[37] = 1'b1; e_se[44] = 1'b1; e_se[53] = 1'b1;
        run_seq("jitter", 60);
        idle(6);

        // SE0 for two bit times while receiving, then back to J
        clear_seq();
        for (int d = 0; d < 22; d++) begin
            s_rc[d] = 1'b1;
            s_dp[d] = (d >= 16);
        end
        for (int k = 2; k <= 17; k++) e_eop[k] = 1'b1;
        e_edge[2] = 1'b1; e_edge[18] = 1'b1;
        e_se[5] = 1'b1; e_se[13] = 1'b1; e_se[21] = 1'b1;
        run_seq("eop", 22);
        idle(6);

        // Receive aborted after 5 bits, then a fresh full byte
        clear_seq();
        for (int d = 0; d < 115; d++) s_rc[d] = (d < 40) || (d >= 50);
        for (int i = 0; i < 5; i++) tog[8*i] = 1'b1;
        for (int i = 0; i < 8; i++) tog[50 + 8*i] = 1'b1;
        build_line(115);
        for (int i = 0; i < 5; i++) e_se[5 + 8*i] = 1'b1;
        for (int i = 0; i < 8; i++) e_se[55 + 8*i] = 1'b1;
        e_br[112] = 1'b1;
        run_seq("abort", 115);
        idle(6);

        // Reset mid-packet clears at once; release resumes after synchroniser fill
        bus.rcving      = 1'b1;
        bus.d_plus_raw  = 1'b0;
        bus.d_minus_raw = 1'b1;
        repeat (10) tick();
        n_rst = 1'b0;
        #1;
        check("rst_async", 0, outs6(), 6'b100000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold", i, outs6(), 6'b100000);
        end
        n_rst = 1'b1;
        rel = '{6'b100000, 6'b011000, 6'b010000, 6'b010000, 6'b010010};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_release", i, outs6(), rel[i]);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got running required finished");
        $fatal(1);
    end
endmodule

// File: doc/rx_timing_unit.md
RX_TIMING_UNIT -- requirements
Module: rx_timing_unit

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 8, giving clk cycles per USB bit time; legal range 4..16.
REQ-002 The block SHALL have parameter SAMPLE_OFFSET, default 3, giving the cycle index within a bit at which shift_enable fires; legal range 1..CLKS_PER_BIT-1.
REQ-003 clk  input  1  system clock; all flops rising-edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 d_plus_raw  input  1  unsynchronised bus D+ line.
REQ-006 d_minus_raw  input  1  unsynchronised bus D- line.
REQ-007 rcving  input  1  receive-in-progress flag from the receiver control unit.
REQ-008 d_plus  output  1  synchronised D+, to the NRZI decoder.
REQ-009 d_minus  output  1  synchronised D-.
REQ-010 d_edge  output  1  one-cycle pulse on any transition of synchronised D+.
REQ-011 eop  output  1  end-of-packet (SE0) indication.
REQ-012 shift_enable  output  1  one-cycle bit-sample strobe to the decoder and shift register.
REQ-013 byte_received  output  1  one-cycle pulse after 8 bits are sampled.

Function
REQ-014 Each raw line SHALL pass through a two-flop synchroniser; d_plus/d_minus are the second-stage flop outputs (raw change at edge k visible at edge k+2).
REQ-015 A d_plus_last flop SHALL capture d_plus every cycle; d_edge = d_plus XOR d_plus_last, decoded from flops only.
REQ-016 eop SHALL be 1 exactly when d_plus==0 and d_minus==0 (from flops, no raw-input path).
REQ-017 A clock counter clk_cnt, width ceil(log2(CLKS_PER_BIT)), SHALL update each cycle: rcving==0 -> 0; else d_edge==1 -> 1; else clk_cnt==CLKS_PER_BIT-1 -> 0; else clk_cnt+1.
REQ-018 shift_enable SHALL equal rcving AND (clk_cnt==SAMPLE_OFFSET), from flops; with no edges it fires once every CLKS_PER_BIT cycles.
REQ-019 d_edge coincident with clk_cnt==SAMPLE_OFFSET: shift_enable SHALL still assert that cycle; clk_cnt reloads 1.
REQ-020 A 3-bit counter bit_cnt SHALL increment (7 wraps to 0) on each shift_enable, hold otherwise, and load 0 whenever rcving==0.
REQ-021 byte_received SHALL be a flop loaded with (rcving AND shift_enable AND bit_cnt==7), so it is high exactly one cycle, the cycle after the 8th shift_enable of a byte.
REQ-022 Back-to-back bytes SHALL be counted with no dead cycle; bit_cnt continues 0..7 across bytes.
REQ-023 rcving dropping mid-byte SHALL clear clk_cnt and bit_cnt at the next edge, with no byte_received for the partial byte.
REQ-024 shift_enable SHALL continue while rcving==1 during eop, so the decoder sees eop and shift_enable together.

Reset
REQ-025 On n_rst low: both D+ synchroniser stages and d_plus_last SHALL be 1; both D- stages 0 (idle J state).
REQ-026 On n_rst low: clk_cnt=0, bit_cnt=0, byte_received=0; hence d_plus=1, d_minus=0, d_edge=0, eop=0, shift_enable=0.
REQ-027 Reset assertion mid-packet SHALL clear all state immediately with no further strobes; release needs no extra cycles beyond synchroniser fill.

Verification
REQ-028 Reset, raw lines idle J (1/0), rcving=0 for 20 cycles -> d_plus=1, d_minus=0, d_edge, eop, shift_enable, byte_received all 0 throughout.
REQ-029 rcving=1, d_plus_raw toggles at edge t -> d_edge high only in cycle t+2; with defaults, shift_enable high at t+5, t+13, t+21 while no further edges.
REQ-030 rcving=1, sync byte 0x80 NRZI-encoded at 8 clk/bit -> 8 shift_enable pulses 8 cycles apart; byte_received high for 1 cycle, the cycle after the 8th; second byte back-to-back -> second byte_received exactly 64 cycles later.
REQ-031 Jitter: bit edges arrive at 7 and 9 cycle spacing -> shift_enable always 3 cycles after each d_edge; no missed or duplicated strobe.
REQ-032 Both raw lines driven 0 for 2 bit times with rcving=1 -> eop=1 from 2 cycles after the raw change and shift_enable still pulsing; lines back to J -> eop=0 2 cycles later.
REQ-033 rcving deasserted after 5 bits, reasserted later -> no byte_received; next byte produces byte_received only after 8 fresh shift_enable pulses.
